// File: rtl/testpattern_gen_pkg.sv
// Shared N64 video window constants, test-pattern enumeration and vdata slice helpers.
`ifndef N64ADV_VDATA_SLICES
`define N64ADV_VDATA_SLICES
`define VD_NVSYNC(cw) (3*(cw)+3)
`define VD_NHSYNC(cw) (3*(cw)+1)
`define VD_SYNC(cw)   3*(cw)+3:3*(cw)
`define VD_RGB(cw)    3*(cw)-1:0
`endif

package n64adv_vparams;

  localparam logic [8:0] VSTART_NTSC_LX1 = 9'd18;
  localparam logic [8:0] VSTOP_NTSC_LX1  = 9'd258;
  localparam logic [8:0] VSTART_PAL_LX1  = 9'd22;
  localparam logic [8:0] VSTOP_PAL_LX1   = 9'd310;

  localparam logic [9:0] HSTART_NTSC = 10'd64;
  localparam logic [9:0] HSTOP_NTSC  = 10'd704;
  localparam logic [9:0] HSTART_PAL  = 10'd60;
  localparam logic [9:0] HSTOP_PAL   = 10'd700;

  localparam logic [9:0] BAR_W_NTSC = (HSTOP_NTSC - HSTART_NTSC) / 10'd8;
  localparam logic [9:0] BAR_W_PAL  = (HSTOP_PAL - HSTART_PAL) / 10'd8;

  typedef enum logic [1:0] {
    TPG_CHECKER = 2'd0,
    TPG_BARS    = 2'd1,
    TPG_RAMP    = 2'd2,
    TPG_BORDER  = 2'd3
  } tpg_pattern_e;

endpackage

// File: rtl/testpattern_gen_bar_lut.sv
// Colour-bar lookup: 3-bit bar index to full-scale {R,G,B}, white..black order.
// Only built when TPG_COLORBARS_EN is defined.
`ifdef TPG_COLORBARS_EN
module tpg_bar_lut #(
  parameter int COLOR_W = 7
) (
  input  logic [2:0]           bar_idx,
  output logic [3*COLOR_W-1:0] rgb
);

  logic [2:0] mask;

  always_comb begin
    mask = 3'b000;
    case (bar_idx)
      3'd0: mask = 3'b111;
      3'd1: mask = 3'b110;
      3'd2: mask = 3'b011;
      3'd3: mask = 3'b010;
      3'd4: mask = 3'b101;
      3'd5: mask = 3'b100;
      3'd6: mask = 3'b001;
      default: mask = 3'b000;
    endcase
  end

  assign rgb = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};

endmodule
`endif

// File: rtl/testpattern_gen.sv
// Frame-synchronous test pattern generator; one VCLK latency, invalid cycles hold all state.
// Define TPG_COLORBARS_EN to build colour bars; otherwise pattern 1 falls back to the checkerboard.
module testpattern_gen
  import n64adv_vparams::*;
#(
  parameter int COLOR_W    = 7,
  parameter int CB_SHIFT   = 0,
  parameter int RAMP_SHIFT = 2
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   palmode,
  input  logic [1:0]             pattern_sel,
  input  logic                   vdata_sync_valid_i,
  input  logic [3:0]             vdata_sync_i,
  output logic                   vdata_valid_o,
  output logic [3*COLOR_W+3:0]   vdata_o
);

  localparam logic [9:0] LVL_MAX = 10'((1 << COLOR_W) - 1);

  logic [9:0] hcnt, hstart, hstop, px, ramp_cnt, ramp_cur, ramp_lvl;
  logic [8:0] vcnt, vstart, vstop, ly;
  tpg_pattern_e sel_q;
  logic vs_fall, hs_fall, active, line_start, border;
  logic [COLOR_W-1:0] chk, grey;
  logic [3*COLOR_W-1:0] rgb;

  // Edges are taken against the sync already registered in the output word.
  assign vs_fall = vdata_sync_valid_i && vdata_o[`VD_NVSYNC(COLOR_W)] && !vdata_sync_i[3];
  assign hs_fall = vdata_sync_valid_i && vdata_o[`VD_NHSYNC(COLOR_W)] && !vdata_sync_i[1];

  assign hstart = palmode ? HSTART_PAL : HSTART_NTSC;
  assign hstop  = palmode ? HSTOP_PAL : HSTOP_NTSC;
  assign vstart = palmode ? VSTART_PAL_LX1 : VSTART_NTSC_LX1;
  assign vstop  = palmode ? VSTOP_PAL_LX1 : VSTOP_NTSC_LX1;

  assign active     = (hcnt >= hstart) && (hcnt < hstop) && (vcnt >= vstart) && (vcnt < vstop);
  assign px         = hcnt - hstart;
  assign ly         = vcnt - vstart;
  assign line_start = (hcnt == hstart);

  assign chk      = (px[CB_SHIFT] == ly[CB_SHIFT]) ? '1 : '0;
  assign ramp_cur = line_start ? '0 : ramp_cnt;
  assign ramp_lvl = ramp_cur >> RAMP_SHIFT;
  assign grey     = (ramp_lvl >= LVL_MAX) ? '1 : ramp_lvl[COLOR_W-1:0];
  assign border   = (px == '0) || (hcnt == hstop - 10'd1) || (ly == '0) || (vcnt == vstop - 9'd1);

`ifdef TPG_COLORBARS_EN
  logic [9:0] bar_w, bar_sub, bar_sub_cur;
  logic [2:0] bar_idx, bar_idx_cur;
  logic [3*COLOR_W-1:0] bar_rgb;

  assign bar_w       = palmode ? BAR_W_PAL : BAR_W_NTSC;
  assign bar_sub_cur = line_start ? '0 : bar_sub;
  assign bar_idx_cur = line_start ? '0 : bar_idx;

  tpg_bar_lut #(.COLOR_W(COLOR_W)) u_bar_lut (
    .bar_idx (bar_idx_cur),
    .rgb     (bar_rgb)
  );

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      bar_sub <= '0;
      bar_idx <= '0;
    end else if (vdata_sync_valid_i) begin
      if (active) begin
        if (bar_sub_cur == bar_w - 10'd1) begin
          bar_sub <= '0;
          bar_idx <= (bar_idx_cur == 3'd7) ? 3'd7 : bar_idx_cur + 3'd1;
        end else begin
          bar_sub <= bar_sub_cur + 10'd1;
          bar_idx <= bar_idx_cur;
        end
      end else if (line_start) begin
        bar_sub <= '0;
        bar_idx <= '0;
      end
    end
  end
`endif

  always_comb begin
    rgb = '0;
    if (active) begin
      case (sel_q)
        TPG_CHECKER: rgb = {3{chk}};
`ifdef TPG_COLORBARS_EN
        TPG_BARS:    rgb = bar_rgb;
`else
        TPG_BARS:    rgb = {3{chk}};
`endif
        TPG_RAMP:    rgb = {3{grey}};
        TPG_BORDER:  rgb = border ? '1 : '0;
        default:     rgb = '0;
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      vdata_valid_o <= 1'b0;
      vdata_o       <= '0;
      hcnt          <= '0;
      vcnt          <= '0;
      sel_q         <= TPG_CHECKER;
      ramp_cnt      <= '0;
    end else begin
      vdata_valid_o <= vdata_sync_valid_i;
      if (vdata_sync_valid_i) begin
        vdata_o[`VD_SYNC(COLOR_W)] <= vdata_sync_i;
        vdata_o[`VD_RGB(COLOR_W)]  <= rgb;

        if (hs_fall) hcnt <= '0;
        else if (hcnt != '1) hcnt <= hcnt + 10'd1;

        // A vsync edge coinciding with an hsync edge still leaves vcnt at zero.
        if (vs_fall) begin
          vcnt  <= '0;
          sel_q <= tpg_pattern_e'(pattern_sel);
        end else if (hs_fall && vcnt != '1) begin
          vcnt <= vcnt + 9'd1;
        end

        if (active) ramp_cnt <= ramp_cur + 10'd1;
        else if (line_start) ramp_cnt <= '0;
      end
    end
  end

endmodule
